odd_issue_scheduler: RTL

Structural-hazard scheduler placed in front of the odd pipe. Each cycle it decides whether the odd-pipe instruction at issue may fire. It holds an instruction back when its writeback would collide with an older instruction on the single odd register-file write port, or when the non-pipelined local-store unit is still busy. It also reports the writeback slot schedule and honours branch flushes from the odd pipe.

---
 rtl/odd_issue_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/odd_issue_scheduler.sv
// Structural-hazard scheduler for the odd pipe: register-file write-port reservation,
// local-store busy tracking and branch-flush kill. Optional stall counter: ODD_SCHED_STALL_CNT_EN.
module odd_issue_scheduler #(
    parameter int MAX_LAT     = 8,
    parameter int LS_BUSY     = 2,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [0:2]  req_unit,
    input  logic [0:3]  req_latency,
    input  logic        req_wr_en,
    input  logic [0:6]  req_addr_rt,
    input  logic        flush,
    output logic        issue_fire,
    output logic        stall,
    output logic        wb_valid,
    output logic [0:6]  wb_addr_rt,
    output logic [0:2]  wb_unit,
    output logic        ls_busy,
    output logic [0:15] stall_cnt
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam int CNT_W = (LS_BUSY > 2) ? $clog2(LS_BUSY) : 1;
    localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);
    localparam logic [0:2]       UNIT_LS   = 3'd6;

    // Current slot contents, flattened out of the per-slot generate blocks
    logic             slot_valid [MAX_LAT];
    logic [0:6]       slot_addr  [MAX_LAT];
    logic [0:2]       slot_unit  [MAX_LAT];
    logic [LAT_W-1:0] slot_lat   [MAX_LAT];
    logic [MAX_LAT-1:0] slot_hit;

    logic [LAT_W-1:0] eff_lat;
    logic             is_ls_req;
    logic             wb_conflict;
    logic             ls_conflict;

    logic [CNT_W-1:0] ls_cnt_reg, ls_cnt_next;
    logic             ls_busy_reg;

    always_comb begin
        eff_lat = MAX_LAT_L;
        if (req_latency == 4'd0) begin
            eff_lat = LAT_W'(1);
        end else if (32'(req_latency) <= MAX_LAT) begin
            eff_lat = LAT_W'(req_latency);
        end
    end

    assign is_ls_req   = (req_unit == UNIT_LS);
    assign wb_conflict = req_wr_en && (|slot_hit);
    assign ls_conflict = is_ls_req && (ls_cnt_reg != '0);
    assign issue_fire  = req_valid && !flush && !wb_conflict && !ls_conflict;
    assign stall       = req_valid && !issue_fire;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAT; gi++) begin : g_slot
            logic             src_valid;
            logic [0:6]       src_addr;
            logic [0:2]       src_unit;
            logic [LAT_W-1:0] src_lat;
            logic             src_kill;
            logic             valid_reg, valid_next;
            logic [0:6]       addr_reg, addr_next;
            logic [0:2]       unit_reg, unit_next;
            logic [LAT_W-1:0] lat_reg, lat_next;

            if (gi < MAX_LAT - 1) begin : g_shift
                assign src_valid = slot_valid[gi+1];
                assign src_addr  = slot_addr[gi+1];
                assign src_unit  = slot_unit[gi+1];
                assign src_lat   = slot_lat[gi+1];
            end else begin : g_top
                assign src_valid = 1'b0;
                assign src_addr  = '0;
                assign src_unit  = '0;
                assign src_lat   = '0;
            end

            // Age after the shift is lat-1-gi; young entries are still speculative
            assign src_kill = flush && src_valid &&
                              (32'(src_lat) < 32'(FLUSH_DEPTH + 1 + gi));

            always_comb begin
                valid_next = src_valid;
                addr_next  = src_addr;
                unit_next  = src_unit;
                lat_next   = src_lat;
                if (src_kill) begin
                    valid_next = 1'b0;
                    addr_next  = '0;
                    unit_next  = '0;
                    lat_next   = '0;
                end
                if (issue_fire && req_wr_en && (eff_lat == LAT_W'(gi + 1))) begin
                    valid_next = 1'b1;
                    addr_next  = req_addr_rt;
                    unit_next  = req_unit;
                    lat_next   = eff_lat;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    addr_reg  <= '0;
                    unit_reg  <= '0;
                    lat_reg   <= '0;
                end else begin
                    valid_reg <= valid_next;
                    addr_reg  <= addr_next;
                    unit_reg  <= unit_next;
                    lat_reg   <= lat_next;
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_addr[gi]  = addr_reg;
            assign slot_unit[gi]  = unit_reg;
            assign slot_lat[gi]   = lat_reg;

            // Slot gi moves into gi-1 on the shift, exactly where a latency-gi request lands
            assign slot_hit[gi] = (gi != 0) && valid_reg && (eff_lat == LAT_W'(gi));
        end
    endgenerate

    assign wb_valid   = slot_valid[0];
    assign wb_addr_rt = slot_addr[0];
    assign wb_unit    = slot_unit[0];

    // The access already started keeps the unit busy even across a flush
    always_comb begin
        ls_cnt_next = ls_cnt_reg;
        if (issue_fire && is_ls_req) begin
            ls_cnt_next = CNT_W'(LS_BUSY - 1);
        end else if (ls_cnt_reg != '0) begin
            ls_cnt_next = ls_cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ls_cnt_reg  <= '0;
            ls_busy_reg <= 1'b0;
        end else begin
            ls_cnt_reg  <= ls_cnt_next;
            ls_busy_reg <= (ls_cnt_next != '0);
        end
    end

    assign ls_busy = ls_busy_reg;

`ifdef ODD_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule
